// File: rtl/pwm_load_sequencer.sv
// Streams one frame of (pulse width, phase) pairs from drive-data memory into the PWM
// preconditioner, then issues a single UPDATE strobe. Define PWM_LOAD_SYNC_EN to align UPDATE to TIME_CNT==511.
module pwm_load_sequencer #(
    parameter int DEPTH      = 249,
    parameter int RD_LATENCY = 2,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [8:0]    time_cnt,
    input  logic          start,
    output logic [AW-1:0] addr,
    input  logic [8:0]    pulse_width_in,
    input  logic [7:0]    phase_in,
    output logic          din_valid,
    output logic [8:0]    pulse_width,
    output logic [7:0]    phase,
    input  logic          dout_valid,
    output logic          update,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WAIT_PRE,
        WAIT_SYNC,
        UPD
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [2:0]    DRAIN_LAST = 3'(RD_LATENCY);

    state_t                state;
    logic [2:0]            drain_cnt;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic                  sync_hit;

`ifdef PWM_LOAD_SYNC_EN
    // Leave WAIT_SYNC on 510 so UPDATE occupies the 511 cycle and the frame swaps at 0.
    assign sync_hit = (time_cnt == 9'd510);
`else
    logic unused_time_cnt;
    assign unused_time_cnt = ^time_cnt;
    assign sync_hit        = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            drain_cnt <= '0;
            update    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            update <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        busy  <= 1'b1;
                        addr  <= '0;
                    end
                end
                READ: begin
                    if (addr == LAST_ADDR) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                DRAIN: begin
                    // RD_LATENCY+1 cycles: memory latency plus the output register.
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= WAIT_PRE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                WAIT_PRE: begin
                    if (dout_valid) begin
                        state <= WAIT_SYNC;
                    end
                end
                WAIT_SYNC: begin
                    if (sync_hit) begin
                        state  <= UPD;
                        update <= 1'b1;
                    end
                end
                UPD: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    addr  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Valid tracks each issued address through the memory latency to the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe     <= '0;
            din_valid   <= 1'b0;
            pulse_width <= '0;
            phase       <= '0;
        end else begin
            rd_pipe[0] <= (state == READ);
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            din_valid <= rd_pipe[RD_LATENCY-1];
            if (rd_pipe[RD_LATENCY-1]) begin
                pulse_width <= pulse_width_in;
                phase       <= phase_in;
            end
        end
    end

endmodule

// File: tb/tb_pwm_load_sequencer.sv
// Scoreboard bench for pwm_load_sequencer: random memory frames, expected stream and
// UPDATE/DONE cycles derived from the frame timing rules, checked by an independent monitor.
module tb_pwm_load_sequencer;

    localparam int DEPTH = 249;
    localparam int L     = 2;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [8:0]    time_cnt = '0;
    logic          start;
    logic [AW-1:0] addr;
    logic [8:0]    pulse_width_in = '0;
    logic [7:0]    phase_in = '0;
    logic          din_valid;
    logic [8:0]    pulse_width;
    logic [7:0]    phase;
    logic          dout_valid;
    logic          update;
    logic          busy;
    logic          done;

    pwm_load_sequencer #(.DEPTH(DEPTH), .RD_LATENCY(L)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .time_cnt      (time_cnt),
        .start         (start),
        .addr          (addr),
        .pulse_width_in(pulse_width_in),
        .phase_in      (phase_in),
        .din_valid     (din_valid),
        .pulse_width   (pulse_width),
        .phase         (phase),
        .dout_valid    (dout_valid),
        .update        (update),
        .busy          (busy),
        .done          (done)
    );

    typedef struct {
        int         cyc;
        logic [8:0] pw;
        logic [7:0] ph;
    } exp_t;

    exp_t       exp_q[$];
    int         upd_q[$];
    int         done_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [8:0] mem_pw [DEPTH];
    logic [7:0] mem_ph [DEPTH];
    int         mem_pipe [L];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Time counter value in cycle n is n mod 512.
    always @(negedge clk) time_cnt = 9'(cyc);

    // Memory: data for the address seen in cycle c is presented in cycle c+L.
    initial for (int i = 0; i < L; i++) mem_pipe[i] = 0;
    always @(negedge clk) begin
        pulse_width_in = mem_pw[mem_pipe[L-1]];
        phase_in       = mem_ph[mem_pipe[L-1]];
        for (int i = L - 1; i > 0; i--) mem_pipe[i] = mem_pipe[i-1];
        mem_pipe[0] = (int'(addr) < DEPTH) ? int'(addr) : 0;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        int   u;
        #1;
        if (rst_n) begin
            if (din_valid) begin
                if (exp_q.size() == 0) begin
                    chk("din_unexpected", din_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("din_cycle", cyc, e.cyc);
                    chk("pulse_width", pulse_width, e.pw);
                    chk("phase", phase, e.ph);
                end
            end
            if (update) begin
                if (upd_q.size() == 0) begin
                    chk("update_unexpected", update, 0);
                end else begin
                    u = upd_q.pop_front();
                    chk("update_cycle", cyc, u);
                    done_q.push_back(u + 1);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", done, 0);
                end else begin
                    chk("done_cycle", cyc, done_q.pop_front());
                    chk("busy_at_done", busy, 0);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    function automatic int upd_cycle(input int d);
        int u;
        u = d + 2;
`ifdef PWM_LOAD_SYNC_EN
        while ((u % 512) != 511) u++;
`endif
        return u;
    endfunction

    task automatic push_load(input int t0);
        for (int k = 0; k < DEPTH; k++) begin
            mem_pw[k] = 9'($urandom);
            mem_ph[k] = 8'($urandom);
        end
        for (int k = 0; k < DEPTH; k++) begin
            exp_q.push_back('{t0 + L + 2 + k, mem_pw[k], mem_ph[k]});
        end
    endtask

    task automatic give_dout(input int d);
        wait_to(d);
        dout_valid = 1'b1;
        upd_q.push_back(upd_cycle(d));
        tick();
        dout_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_din_valid"}, din_valid, 0);
        chk({tag, "_pulse_width"}, pulse_width, 0);
        chk({tag, "_phase"}, phase, 0);
        chk({tag, "_update"}, update, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Assumes the DUT is idle; returns one cycle after DONE.
    task automatic run_load(input int dly, input int tc_target, input bit noise);
        int t0;
        int d;
        start = 1'b1;
        t0    = cyc;
        push_load(t0);
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("addr_first", addr, 0);
        if (noise) begin
            wait_to(t0 + 40);
            start      = 1'b1;
            dout_valid = 1'b1;
            tick();
            start      = 1'b0;
            dout_valid = 1'b0;
        end
        wait_to(t0 + DEPTH);
        chk("addr_last", addr, DEPTH - 1);
        d = t0 + DEPTH + L + 2 + dly;
        if (tc_target >= 0) while ((d % 512) != tc_target) d++;
        give_dout(d);
        wait_to(upd_cycle(d) + 2);
        chk("busy_after_done", busy, 0);
        chk("addr_idle", addr, 0);
    endtask

    initial begin
        int t0;
        int d;
        int u;
        rst_n      = 1'b0;
        start      = 1'b0;
        dout_valid = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check_all_zero("reset");

        // DOUT_VALID in the very first WAIT_PRE cycle, plus ignored START/DOUT_VALID noise.
        run_load(0, -1, 1'b1);
        run_load(0, 100, 1'b0);
        run_load(0, 511, 1'b0);

        // START held high: second load accepted in the DONE cycle.
        start = 1'b1;
        t0    = cyc;
        push_load(t0);
        tick();
        d = t0 + DEPTH + L + 2 + 3;
        give_dout(d);
        u = upd_cycle(d);
        wait_to(u + 1);
        push_load(u + 1);
        tick();
        chk("addr_b2b", addr, 0);
        chk("busy_b2b", busy, 1);
        wait_to(u + 6);
        start = 1'b0;
        wait_to(u + 30);
        start = 1'b1;
        tick();
        start = 1'b0;
        d = (u + 1) + DEPTH + L + 2;
        give_dout(d);
        wait_to(upd_cycle(d) + 2);
        chk("busy_after_b2b", busy, 0);

        // Reset after channel 100 has been streamed.
        start = 1'b1;
        t0    = cyc;
        push_load(t0);
        tick();
        start = 1'b0;
        wait_to(t0 + L + 2 + 100);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_all_zero("midreset");
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check_all_zero("after_midreset");
        run_load($urandom_range(0, 20), -1, 1'b0);
        run_load($urandom_range(0, 20), -1, 1'b1);

        repeat (5) tick();
        chk("stream_left", exp_q.size(), 0);
        chk("update_left", upd_q.size(), 0);
        chk("done_left", done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/pwm_load_sequencer.md
# pwm_load_sequencer

Sequences one full frame load into the PWM datapath. On START it reads DEPTH (pulse width, phase) pairs from the drive-data memory and streams them to the PWM preconditioner with DIN_VALID. It then waits for the preconditioner's DOUT_VALID and issues a single UPDATE pulse, aligned to the TIME_CNT period boundary, so that every per-channel PWM buffer switches to the new frame in the same cycle. It sits between the drive-data memory and the pwm block.

## Interface
- DEPTH, 249: channels per frame; ADDR width AW = $clog2(DEPTH).
- RD_LATENCY, 2: memory read latency in cycles, ADDR to PULSE_WIDTH_IN/PHASE_IN; legal range 1..4.
- CLK  in  1  single clock; all logic is on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- TIME_CNT  in  9  free-running PWM time counter, 0..511, wraps 511→0.
- START  in  1  load request; sampled only in IDLE.
- ADDR  out  AW  memory read address.
- PULSE_WIDTH_IN  in  9  memory data, valid RD_LATENCY cycles after ADDR.
- PHASE_IN  in  8  memory data, valid RD_LATENCY cycles after ADDR.
- DIN_VALID  out  1  stream-valid strobe to the preconditioner.
- PULSE_WIDTH  out  9  registered pulse width to the preconditioner.
- PHASE  out  8  registered phase to the preconditioner.
- DOUT_VALID  in  1  preconditioner reports the frame is complete.
- UPDATE  out  1  one-cycle latch strobe to the PWM buffers.
- BUSY  out  1  high from START acceptance until DONE.
- DONE  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE → READ on START.
  - READ: issues ADDR 0..DEPTH-1 on consecutive cycles → DRAIN after DEPTH-1 is issued.
  - DRAIN: waits RD_LATENCY+1 cycles, until the last DIN_VALID has been driven → WAIT_PRE.
  - WAIT_PRE → WAIT_SYNC on DOUT_VALID.
  - WAIT_SYNC → UPD as described in Configuration.
  - UPD: UPDATE is high for this one cycle → IDLE.
- DIN_VALID, PULSE_WIDTH and PHASE come from a RD_LATENCY-deep valid shift register plus one output register. The data for ADDR=k appears exactly RD_LATENCY+1 cycles after ADDR=k is driven.
- DIN_VALID is high for exactly DEPTH consecutive cycles per load, and the channel order is 0..DEPTH-1.
- ADDR holds DEPTH-1 after READ ends and returns to 0 in IDLE.
- START while BUSY=1 is ignored and is not queued.
- DOUT_VALID outside WAIT_PRE is ignored. A DOUT_VALID arriving in the same cycle as the state enters WAIT_PRE is accepted.
- The block applies no timeout; WAIT_PRE holds until DOUT_VALID arrives.

## Timing
- Reset values: ADDR=0, DIN_VALID=0, PULSE_WIDTH=0, PHASE=0, UPDATE=0, BUSY=0, DONE=0; state is IDLE; the shift register is cleared.
- START is seen high at edge t0. BUSY=1 and ADDR=0 from t0+1. ADDR=DEPTH-1 at t0+DEPTH.
- First DIN_VALID at t0+1+RD_LATENCY+1; last DIN_VALID at t0+DEPTH+RD_LATENCY+1.
- UPDATE is registered, and UPDATE→DONE spacing is fixed: DONE=1 and BUSY=0 in the cycle immediately after UPDATE.
- A back-to-back START is accepted in the cycle DONE is high, because the state is IDLE in that cycle.
- Reset mid-operation: all outputs return to their reset values immediately; any partial stream is abandoned. The next START restarts from channel 0. The PWM buffers keep the previous frame because no UPDATE was issued.

## Configuration
- PWM_LOAD_SYNC_EN defined:
  - WAIT_SYNC moves to UPD at the edge where TIME_CNT==510, so UPDATE is high during the cycle TIME_CNT==511 and the new frame takes effect from TIME_CNT==0.
  - If WAIT_SYNC is entered while TIME_CNT==511, the block waits a full period.
- PWM_LOAD_SYNC_EN undefined:
  - WAIT_SYNC lasts exactly one cycle, so UPDATE is asserted 2 cycles after DOUT_VALID is accepted, regardless of TIME_CNT.

## Test plan
- Reset, then idle 10 cycles → all outputs 0; START pulsed mid-reset has no effect.
- DEPTH=249, RD_LATENCY=2, memory returns PULSE_WIDTH_IN={ADDR,1'b0}>>1 and PHASE_IN=ADDR, START at t0 → exactly 249 DIN_VALID cycles, first at t0+4, in order 0..248, data matching the memory model.
- SYNC_EN defined, DOUT_VALID given while TIME_CNT=100 → UPDATE high only while TIME_CNT=511, DONE the next cycle at TIME_CNT=0. DOUT_VALID given at TIME_CNT=511 → UPDATE 512 cycles later.
- SYNC_EN undefined, DOUT_VALID at cycle d → UPDATE at d+2, DONE at d+3.
- START held high continuously → second load's ADDR=0 appears the cycle after DONE; START pulses during BUSY produce no extra DIN_VALID.
- RST_N asserted after channel 100 is streamed, then released and START given → DIN_VALID count restarts at channel 0; no UPDATE is seen before the new load's DOUT_VALID.
